muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) beside the combinational ALU in the execute stage. It takes one operation per valid/ready handshake and computes one result bit per cycle with a shift-add / restoring-divide datapath. The result is held under output backpressure. Pipeline flush aborts an in-flight operation.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_step.sv | 39 +++
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
//   mdop_t      : M-extension operation in funct3 encoding
//   mdu_state_t : control FSM states
package mdu_pkg;

    localparam int unsigned MDU_DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mdop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath over a 2*W accumulator.
//   acc_in  : accumulator {hi, lo}
//   opnd    : |A| for multiply (addend), |B| for divide (divisor)
//   is_div  : 1 = restoring shift-subtract, 0 = add-shift
//   acc_out : next accumulator
module mdu_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] acc_in,
    input  logic [DATA_WIDTH-1:0]   opnd,
    input  logic                    is_div,
    output logic [2*DATA_WIDTH-1:0] acc_out
);

    localparam int unsigned W = DATA_WIDTH;

    logic [W:0] add_sum;
    logic [W:0] sh_hi;
    logic [W:0] diff;

    always_comb begin
        acc_out = '0;
        // multiply: lo holds the multiplier, LSB selects the add, then shift right
        add_sum = {1'b0, acc_in[2*W-1:W]} + (acc_in[0] ? {1'b0, opnd} : '0);
        // divide: shift partial remainder left (W+1 bits), trial subtract
        sh_hi   = acc_in[2*W-1:W-1];
        diff    = sh_hi - {1'b0, opnd};
        if (is_div) begin
            if (!diff[W]) begin
                acc_out = {diff[W-1:0], acc_in[W-2:0], 1'b1};
            end else begin
                acc_out = {sh_hi[W-1:0], acc_in[W-2:0], 1'b0};
            end
        end else begin
            acc_out = {add_sum, acc_in[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit, one result bit per cycle.
//   clk, rst           : clock, async active-high reset
//   flush              : synchronous abort of any operation in flight
//   in_valid/in_ready  : operation request handshake (mdop, opr_a, opr_b)
//   out_valid/out_ready: result handshake; opr_result held under backpressure
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MDU_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  mdop_t                 mdop,
    input  logic [DATA_WIDTH-1:0] opr_a,
    input  logic [DATA_WIDTH-1:0] opr_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] opr_result
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned AW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    mdu_state_t    state_q, state_d;
    mdop_t         op_q, op_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
    logic [W-1:0]  res_q, res_d;
    logic          vld_q, vld_d;

    logic [AW-1:0] step_acc;

    // accept-time decode of operand signs, magnitudes and special cases
    logic          a_signed, b_signed, sa, sb;
    logic [W-1:0]  a_mag, b_mag;
    logic          div_zero, div_ovf;
    logic [W-1:0]  spec_res;

    assign a_signed = mdop inside {MULH, MULHSU, DIV, REM};
    assign b_signed = mdop inside {MULH, DIV, REM};
    assign sa       = a_signed & opr_a[W-1];
    assign sb       = b_signed & opr_b[W-1];
    assign a_mag    = sa ? -opr_a : opr_a;
    assign b_mag    = sb ? -opr_b : opr_b;
    assign div_zero = mdop[2] && (opr_b == '0);
    assign div_ovf  = (mdop == DIV || mdop == REM) &&
                      (opr_a == {1'b1, {(W-1){1'b0}}}) && (opr_b == '1);

    // mdop[1] separates REM* (6,7) from DIV* (4,5)
    always_comb begin
        spec_res = '0;
        if (div_zero) begin
            spec_res = mdop[1] ? opr_a : '1;
        end else if (div_ovf) begin
            spec_res = mdop[1] ? '0 : opr_a;
        end
    end

    mdu_step #(.DATA_WIDTH(W)) u_step (
        .acc_in  (acc_q),
        .opnd    (opnd_q),
        .is_div  (op_q[2]),
        .acc_out (step_acc)
    );

    // sign correction and result select from the final iteration
    logic [AW-1:0] prod;
    logic [W-1:0]  quo, rem, fin;

    always_comb begin
        prod = neg_quo_q ? -step_acc : step_acc;
        quo  = step_acc[W-1:0];
        rem  = step_acc[AW-1:W];
        case (op_q)
            MUL:                fin = prod[W-1:0];
            MULH, MULHSU, MULHU: fin = prod[AW-1:W];
            DIV, DIVU:          fin = neg_quo_q ? -quo : quo;
            default:            fin = neg_rem_q ? -rem : rem;
        endcase
    end

    // next-state and datapath control
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        vld_d     = vld_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d      = mdop;
                    neg_quo_d = sa ^ sb;
                    neg_rem_d = sa;
                    if (div_zero || div_ovf) begin
                        state_d = DONE;
                        vld_d   = 1'b1;
                        res_d   = spec_res;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(W - 1);
                        opnd_d  = mdop[2] ? b_mag : a_mag;
                        acc_d   = {{W{1'b0}}, (mdop[2] ? a_mag : b_mag)};
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    vld_d   = 1'b1;
                    res_d   = fin;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    res_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= MUL;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
            vld_q     <= vld_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = vld_q;
    assign opr_result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at DATA_WIDTH = 32.
module tb_muldiv_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    mdop_t       mdop;
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] opr_result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mdop       (mdop),
        .opr_a      (opr_a),
        .opr_b      (opr_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .opr_result (opr_result)
    );

    always #5 clk = ~clk;

    // Present one op for one cycle (caller sits at posedge+1), then wait
    // for out_valid. lat = cycles after the accept cycle until out_valid.
    task automatic run_op(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        mdop = op; opr_a = a; opr_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; opr_a = 32'hA5A5_5A5A; opr_b = 32'h1234_5678;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = opr_result;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (opr_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", opr_result); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        mdop_t       ops [4] = '{MUL, MULH, MULHU, MULHSU};
        logic [31:0] as  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] r;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], r, lat);
            checks++; if (r !== exp[i]) begin errors++; $display("FAIL mul_%0d: got %h want %h", i, r, exp[i]); end
            checks++; if (lat != 33) begin errors++; $display("FAIL mul_lat_%0d: got %0d want 33", i, lat); end
            ack();
            checks++; if (out_valid !== 1'b0 || opr_result !== 32'h0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL mul_post_%0d: got v=%b r=%h rdy=%b want 0 0 1", i, out_valid, opr_result, in_ready);
            end
        end
    endtask

    task automatic test_div();
        mdop_t       ops [4] = '{DIV, REM, DIVU, REMU};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] r;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], r, lat);
            checks++; if (r !== exp[i]) begin errors++; $display("FAIL div_%0d: got %h want %h", i, r, exp[i]); end
            checks++; if (lat != 33) begin errors++; $display("FAIL div_lat_%0d: got %0d want 33", i, lat); end
            ack();
        end
    endtask

    task automatic test_div_special();
        mdop_t       ops [6] = '{DIV, REM, DIVU, REMU, DIV, REM};
        logic [31:0] as  [6] = '{32'd5, 32'd5, 32'd9, 32'd9, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd9, 32'h8000_0000, 32'd0};
        logic [31:0] r;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], r, lat);
            checks++; if (r !== exp[i]) begin errors++; $display("FAIL special_%0d: got %h want %h", i, r, exp[i]); end
            checks++; if (lat != 1) begin errors++; $display("FAIL special_lat_%0d: got %0d want 1", i, lat); end
            ack();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        int lat;
        run_op(MULHU, 32'h1234_5678, 32'h0001_0000, r, lat);
        checks++; if (r !== 32'h0000_1234) begin errors++; $display("FAIL bp_result: got %h want 00001234", r); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (opr_result !== 32'h0000_1234 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: got r=%h v=%b rdy=%b want 00001234 1 0", i, opr_result, out_valid, in_ready);
            end
        end
        ack();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_idle: got rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
        run_op(DIVU, 32'd1000, 32'd10, r, lat);
        checks++; if (r !== 32'd100) begin errors++; $display("FAIL bp_next: got %h want 00000064", r); end
        ack();
    endtask

    task automatic test_flush();
        int rises = 0;
        mdop = MUL; opr_a = 32'd6; opr_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
        checks++; if (opr_result !== 32'h0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_calc: got r=%h rdy=%b want 0 0", opr_result, in_ready);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        checks++; if (rises != 0) begin errors++; $display("FAIL flush_no_result: got %0d valid cycles want 0", rises); end
        mdop = DIVU; opr_a = 32'd8; opr_b = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle: got rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_rst();
        logic [31:0] r;
        int lat;
        int rises = 0;
        mdop = MUL; opr_a = 32'd9; opr_b = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 19; i++) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || opr_result !== 32'h0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_calc: got v=%b r=%h rdy=%b want 0 0 1", out_valid, opr_result, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(REMU, 32'd17, 32'd5, r, lat);
        checks++; if (r !== 32'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL rst_done_setup: got %h want 2", r); end
        #3 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || opr_result !== 32'h0) begin
            errors++; $display("FAIL rst_done: got v=%b r=%h want 0 0", out_valid, opr_result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        checks++; if (rises != 0) begin errors++; $display("FAIL rst_no_result: got %0d valid cycles want 0", rises); end
        run_op(MUL, 32'd3, 32'd4, r, lat);
        checks++; if (r !== 32'd12) begin errors++; $display("FAIL rst_fresh_mul: got %h want 0000000c", r); end
        ack();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mdop = MUL; opr_a = '0; opr_b = '0;
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_backpressure();
        test_flush();
        test_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
